// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - register-file write-port controller: clear sweep, then A/B arbitration
// A (core writeback) has priority; B is forced after STARVE_MAX consecutive losses.
module regfile_wb_ctrl #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    output logic            init_busy,
    output logic            regWrite,
    output logic [AW-1:0]   rd_data,
    output logic [XLEN-1:0] write_data
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [SW-1:0] starve;
    logic          running;
    logic          force_b;

    always_comb begin
        running   = (state == S_RUN);
        init_busy = (state == S_INIT);
        force_b   = running && (starve == STARVE_LIM);
        a_ready   = running && a_valid && !(force_b && b_valid);
        b_ready   = running && b_valid && !a_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_INIT;
            idx        <= AW'(1);
            starve     <= '0;
            regWrite   <= 1'b0;
            rd_data    <= '0;
            write_data <= '0;
        end else if (state == S_INIT) begin
            regWrite   <= 1'b1;
            rd_data    <= idx;
            write_data <= '0;
            idx        <= idx + AW'(1);
            starve     <= '0;
            // Leave the sweep on the edge that drives the last register.
            if (idx == LAST_IDX) begin
                state <= S_RUN;
            end
        end else begin
            // Writes to x0 are accepted and swallowed: index/data update, enable stays low.
            if (a_ready) begin
                regWrite   <= |a_rd;
                rd_data    <= a_rd;
                write_data <= a_data;
            end else if (b_ready) begin
                regWrite   <= |b_rd;
                rd_data    <= b_rd;
                write_data <= b_data;
            end else begin
                regWrite   <= 1'b0;
            end

            if (b_valid && a_ready) begin
                if (starve != STARVE_LIM) begin
                    starve <= starve + SW'(1);
                end
            end else begin
                starve <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - directed self-checking bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        init_busy;
    logic        regWrite;
    logic [4:0]  rd_data;
    logic [31:0] write_data;

    int total = 0;
    int bad   = 0;

    regfile_wb_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_rd       (a_rd),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_rd       (b_rd),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .init_busy  (init_busy),
        .regWrite   (regWrite),
        .rd_data    (rd_data),
        .write_data (write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_we"}, 32'(regWrite), 32'(we));
        chk({tag, "_rd"}, 32'(rd_data), 32'(rd));
        chk({tag, "_wd"}, write_data, d);
    endtask

    task automatic sweep(input string tag);
        for (int i = 1; i <= 31; i++) begin
            tick();
            check_wr(tag, 1'b1, 5'(i), 32'h0);
            chk({tag, "_busy"}, 32'(init_busy), (i == 31) ? 32'd0 : 32'd1);
            if (i < 31) begin
                chk({tag, "_ardy"}, 32'(a_ready), 32'd0);
                chk({tag, "_brdy"}, 32'(b_ready), 32'd0);
            end
            if (i == 30) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
        end
        tick();
        chk({tag, "_idle_we"}, 32'(regWrite), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;

        // 1: reset state then clear sweep, with both requesters knocking
        tick(); tick();
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        chk("rst_busy", 32'(init_busy), 32'd1);
        reset   = 1'b0;
        a_valid = 1'b1; a_rd = 5'd6; a_data = 32'h66;
        b_valid = 1'b1; b_rd = 5'd8; b_data = 32'h88;
        sweep("sw");

        // 2: single A write, latency 1
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        chk("t2_ardy", 32'(a_ready), 32'd1);
        chk("t2_brdy", 32'(b_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        check_wr("t2", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        chk("t2_idle", 32'(regWrite), 32'd0);

        // 3: both held, 4:1 grant pattern
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA3;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hB7;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("t3_ardy", 32'(a_ready), (c % 5 == 4) ? 32'd0 : 32'd1);
            chk("t3_brdy", 32'(b_ready), (c % 5 == 4) ? 32'd1 : 32'd0);
            tick();
            if (c % 5 == 4) check_wr("t3b", 1'b1, 5'd7, 32'hB7);
            else            check_wr("t3a", 1'b1, 5'd3, 32'hA3);
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // 4: B to x0 is swallowed, then B to x9
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h1234;
        #1;
        chk("t4_brdy0", 32'(b_ready), 32'd1);
        tick();
        b_rd = 5'd9;
        check_wr("t4_x0", 1'b0, 5'd0, 32'h1234);
        #1;
        chk("t4_brdy9", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        check_wr("t4_x9", 1'b1, 5'd9, 32'h1234);
        tick();
        chk("t4_idle", 32'(regWrite), 32'd0);

        // 5: reset sampled on the edge that would register the x12 write
        a_valid = 1'b1; a_rd = 5'd12; a_data = 32'hC;
        reset   = 1'b1;
        tick();
        a_valid = 1'b0;
        reset   = 1'b0;
        check_wr("t5_rst", 1'b0, 5'd0, 32'h0);
        chk("t5_busy", 32'(init_busy), 32'd1);
        sweep("t5sw");

        // 6: same rd from both; A first, B forced after four losses
        a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h1;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h2;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t6_brdy", 32'(b_ready), (c == 4) ? 32'd1 : 32'd0);
            tick();
            if (c == 4) begin
                b_valid = 1'b0;
                check_wr("t6b", 1'b1, 5'd4, 32'h2);
            end else begin
                check_wr("t6a", 1'b1, 5'd4, 32'h1);
            end
        end
        #1;
        chk("t6_ardy_after", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        check_wr("t6a2", 1'b1, 5'd4, 32'h1);
        tick();
        chk("t6_idle", 32'(regWrite), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
